// File: rtl/warship_link_rx.sv
// Receive side of the inter-board player link. It deserialises 13-bit frames
// (start, 10 data, even parity, stop) and presents the peer's ready/hit/coordinate state.
module warship_link_rx #(
  parameter int CLK_DIV        = 868,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  output logic       ready2,
  output logic       hit2,
  output logic [7:0] ship_cords_in,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       link_lost
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [CW-1:0] TO_MAX    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_ONE     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [9:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            ready2_q, ready2_d;
  logic            hit2_q, hit2_d;
  logic [7:0]      cords_q, cords_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            link_lost_q, link_lost_d;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic            half_end, bit_end, frame_good, frame_bad;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      timer_q       <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      ready2_q      <= 1'b0;
      hit2_q        <= 1'b0;
      cords_q       <= '1;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      link_lost_q   <= 1'b1;
      to_cnt_q      <= '0;
    end else begin
      rx_meta_q     <= rx_line;
      rx_s_q        <= rx_meta_q;
      timer_q       <= timer_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      ready2_q      <= ready2_d;
      hit2_q        <= hit2_d;
      cords_q       <= cords_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      link_lost_q   <= link_lost_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  always_comb begin
    half_end = (timer_q == HALF_LAST);
    bit_end  = (timer_q == BIT_LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!rx_s_q) state_d = S_START;
      S_START:     if (half_end) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:      if (bit_end && bit_idx_q == 4'd9) state_d = S_PARITY;
      S_PARITY:    if (bit_end) state_d = S_STOP;
      S_STOP:      if (bit_end) state_d = rx_s_q ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (rx_s_q) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d       = timer_q + T_ONE;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    ready2_d      = ready2_q;
    hit2_d        = hit2_q;
    cords_d       = cords_q;
    link_lost_d   = link_lost_q;
    to_cnt_d      = to_cnt_q;
    frame_good    = 1'b0;
    frame_bad     = 1'b0;

    case (state_q)
      S_IDLE, S_WAIT_IDLE: timer_d = '0;
      S_START: begin
        bit_idx_d = '0;
        if (half_end) timer_d = '0;
      end
      S_DATA: if (bit_end) begin
        timer_d   = '0;
        shift_d   = {rx_s_q, shift_q[9:1]};
        bit_idx_d = bit_idx_q + 4'd1;
      end
      S_PARITY: if (bit_end) begin
        timer_d  = '0;
        parity_d = rx_s_q;
      end
      S_STOP: if (bit_end) begin
        timer_d    = '0;
        frame_good = rx_s_q && !(^{parity_q, shift_q});
        frame_bad  = !frame_good;
      end
      default: timer_d = '0;
    endcase

    // A good frame takes priority over a timeout expiring on the same edge.
    if (frame_good) begin
      to_cnt_d    = '0;
      link_lost_d = 1'b0;
      ready2_d    = shift_q[0];
      hit2_d      = shift_q[1];
      cords_d     = shift_q[9:2];
    end else begin
      if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + C_ONE;
      if (to_cnt_d == TO_MAX) begin
        link_lost_d = 1'b1;
        ready2_d    = 1'b0;
        hit2_d      = 1'b0;
      end
    end

    frame_valid_d = frame_good;
    frame_err_d   = frame_bad;
  end

  assign ready2        = ready2_q;
  assign hit2          = hit2_q;
  assign ship_cords_in = cords_q;
  assign frame_valid   = frame_valid_q;
  assign frame_err     = frame_err_q;
  assign link_lost     = link_lost_q;

endmodule

// File: tb/tb_warship_link_rx.sv
// Directed bench for warship_link_rx: a table of frames plus hand-written
// sequences for break, glitch, timeout, timeout/frame race and mid-frame reset.
module tb_warship_link_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_line = 1'b1;
  logic       ready2, hit2, frame_valid, frame_err, link_lost;
  logic [7:0] ship_cords_in;

  int checks = 0;
  int errors = 0;
  int vcnt = 0, ecnt = 0, llcnt = 0;

  warship_link_rx #(.CLK_DIV(16), .TIMEOUT_CYCLES(500)) dut (
    .clk(clk), .rst(rst), .rx_line(rx_line),
    .ready2(ready2), .hit2(hit2), .ship_cords_in(ship_cords_in),
    .frame_valid(frame_valid), .frame_err(frame_err), .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  // Pulse-width-sensitive counters: a pulse longer than one cycle counts more than once.
  always @(negedge clk) begin
    if (frame_valid) vcnt++;
    if (frame_err)   ecnt++;
    if (link_lost)   llcnt++;
  end

  typedef struct {
    logic       r;
    logic       h;
    logic [7:0] c;
    logic       pflip;
    int         gap;
    int         ev;
    int         ee;
    logic       er;
    logic       eh;
    logic [7:0] ec;
    logic       el;
  } vec_t;

  vec_t vecs[6];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rx_line = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2);
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    tick(16);
  endtask

  task automatic send_frame(input logic r, input logic h, input logic [7:0] c,
                            input logic pflip, input logic stop_v, input int stop_bits);
    logic [9:0] d;
    d = {c, h, r};
    send_bit(1'b0);
    for (int i = 0; i < 10; i++) send_bit(d[i]);
    send_bit((^d) ^ pflip);
    rx_line = stop_v;
    tick(16 * stop_bits);
    rx_line = 1'b1;
  endtask

  task automatic chk_out(input string nm, input logic r, input logic h,
                         input logic [7:0] c, input logic l);
    chk({nm, " ready2"}, 32'(ready2), 32'(r));
    chk({nm, " hit2"}, 32'(hit2), 32'(h));
    chk({nm, " cords"}, 32'(ship_cords_in), 32'(c));
    chk({nm, " link_lost"}, 32'(link_lost), 32'(l));
  endtask

  initial begin
    int v0, e0, l0;

    vecs[0] = '{1'b1, 1'b0, 8'h2A, 1'b1, 8, 0, 1, 1'b0, 1'b0, 8'hFF, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 8'h2A, 1'b0, 8, 1, 0, 1'b1, 1'b0, 8'h2A, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'h33, 1'b1, 8, 0, 1, 1'b1, 1'b0, 8'h2A, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 8'h55, 1'b0, 0, 1, 0, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'hFF, 1'b0, 8, 1, 0, 1'b0, 1'b1, 8'hFF, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 8, 1, 0, 1'b0, 1'b0, 8'h00, 1'b0};

    do_reset();
    chk_out("reset", 1'b0, 1'b0, 8'hFF, 1'b1);
    chk("reset frame_valid", 32'(frame_valid), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);

    foreach (vecs[i]) begin
      v0 = vcnt; e0 = ecnt;
      send_frame(vecs[i].r, vecs[i].h, vecs[i].c, vecs[i].pflip, 1'b1, 1);
      chk($sformatf("vec%0d valid pulses", i), 32'(vcnt - v0), 32'(vecs[i].ev));
      chk($sformatf("vec%0d err pulses", i), 32'(ecnt - e0), 32'(vecs[i].ee));
      chk_out($sformatf("vec%0d", i), vecs[i].er, vecs[i].eh, vecs[i].ec, vecs[i].el);
      tick(vecs[i].gap);
    end
    tick(40);
    chk_out("hold after table", 1'b0, 1'b0, 8'h00, 1'b0);

    // Stop bit held low (break) for three bit times, then a good frame.
    do_reset();
    v0 = vcnt; e0 = ecnt;
    send_frame(1'b1, 1'b0, 8'h2A, 1'b0, 1'b0, 3);
    tick(32);
    chk("break err pulses", 32'(ecnt - e0), 32'd1);
    chk("break valid pulses", 32'(vcnt - v0), 32'd0);
    send_frame(1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1);
    chk("post-break valid pulses", 32'(vcnt - v0), 32'd1);
    chk("post-break err pulses", 32'(ecnt - e0), 32'd1);
    chk_out("post-break", 1'b1, 1'b1, 8'h55, 1'b0);

    // Short low glitch while idle is a false start.
    tick(8);
    v0 = vcnt; e0 = ecnt;
    rx_line = 1'b0;
    tick(4);
    rx_line = 1'b1;
    tick(40);
    chk("glitch valid pulses", 32'(vcnt - v0), 32'd0);
    chk("glitch err pulses", 32'(ecnt - e0), 32'd0);
    send_frame(1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1);
    chk_out("post-glitch", 1'b0, 1'b1, 8'h81, 1'b0);

    // Idle timeout: link_lost rises 500 cycles after the last good frame.
    do_reset();
    send_frame(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 1);
    tick(300);
    chk_out("timeout before", 1'b1, 1'b1, 8'h77, 1'b0);
    tick(200);
    chk_out("timeout after", 1'b0, 1'b0, 8'h77, 1'b1);
    send_frame(1'b1, 1'b0, 8'h99, 1'b0, 1'b1, 1);
    chk_out("timeout recover", 1'b1, 1'b0, 8'h99, 1'b0);

    // Frame completing exactly when the counter would reach the timeout.
    do_reset();
    send_frame(1'b1, 1'b0, 8'h12, 1'b0, 1'b1, 1);
    tick(292);
    l0 = llcnt;
    send_frame(1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1);
    tick(2);
    chk("race link_lost cycles", 32'(llcnt - l0), 32'd0);
    chk_out("race", 1'b0, 1'b1, 8'h34, 1'b0);

    // Reset asserted during d5 of a frame.
    send_frame(1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1);
    chk_out("pre-reset", 1'b1, 1'b1, 8'h3C, 1'b0);
    v0 = vcnt; e0 = ecnt;
    begin
      logic [9:0] d;
      d = {8'hAA, 1'b1, 1'b0};
      send_bit(1'b0);
      for (int i = 0; i < 5; i++) send_bit(d[i]);
      rx_line = d[5];
      tick(8);
    end
    rst = 1'b0;
    rx_line = 1'b1;
    tick(2);
    chk_out("in reset", 1'b0, 1'b0, 8'hFF, 1'b1);
    rst = 1'b1;
    tick(200);
    chk("mid-reset valid pulses", 32'(vcnt - v0), 32'd0);
    chk("mid-reset err pulses", 32'(ecnt - e0), 32'd0);
    chk_out("after mid-reset", 1'b0, 1'b0, 8'hFF, 1'b1);
    send_frame(1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1);
    chk("post-reset valid pulses", 32'(vcnt - v0), 32'd1);
    chk_out("post-reset frame", 1'b0, 1'b0, 8'hC3, 1'b0);

    tick(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
